// File: rtl/fwd_hazard_unit.sv
// fwd_hazard_unit
//   Forwarding and load-use hazard unit for the pipelined MIPS core.
//   Compares the source operands of the instruction in ID against the
//   destinations held in ID/EX and EX/MEM. It registers per-operand
//   forwarding selects so that they are valid when the consumer reaches EX.
//   It also detects load-use hazards and holds IF/ID for LOAD_STALL_CYCLES
//   cycles while bubbling ID/EX, and it keeps a saturating stall-cycle count.
//
// Ports
//   CLOCK, RESET_N   clock (rising edge) / asynchronous active-low reset
//   ID_Valid         ID holds a real instruction
//   ID_Flush         ID instruction squashed
//   ID_Src_Addr      packed source addresses, operand i at [i*REG_ADDR_W +: REG_ADDR_W]
//   ID_Src_Used      operand i is actually read
//   IDEX_Rd/RegWrite/MemRead   producer in ID/EX
//   EXMEM_Rd/RegWrite          producer in EX/MEM
//   Fwd_Sel          registered select per operand: 00 RF, 01 MEM/WB, 10 EX/MEM
//   Stall            hold PC and IF/ID (combinational)
//   IDEX_Bubble      insert NOP into ID/EX (same as Stall)
//   Stall_Count      saturating count of Stall cycles
module fwd_hazard_unit #(
    parameter int REG_ADDR_W        = 5,
    parameter int NUM_SRC           = 2,
    parameter int LOAD_STALL_CYCLES = 1,
    parameter int ZERO_REG_EN       = 1
) (
    input  logic                          CLOCK,
    input  logic                          RESET_N,
    input  logic                          ID_Valid,
    input  logic                          ID_Flush,
    input  logic [NUM_SRC*REG_ADDR_W-1:0] ID_Src_Addr,
    input  logic [NUM_SRC-1:0]            ID_Src_Used,
    input  logic [REG_ADDR_W-1:0]         IDEX_Rd,
    input  logic                          IDEX_RegWrite,
    input  logic                          IDEX_MemRead,
    input  logic [REG_ADDR_W-1:0]         EXMEM_Rd,
    input  logic                          EXMEM_RegWrite,
    output logic [2*NUM_SRC-1:0]          Fwd_Sel,
    output logic                          Stall,
    output logic                          IDEX_Bubble,
    output logic [15:0]                   Stall_Count
);

    localparam int CNT_W = $clog2(LOAD_STALL_CYCLES) + 1;

    typedef enum logic {
        IDLE,
        STALL
    } state_t;

    state_t             state, state_next;
    logic [CNT_W-1:0]   cnt, cnt_next;
    logic [2*NUM_SRC-1:0] cand;
    logic               load_hit;
    logic               hazard;
    logic               idex_zero_blk;
    logic               exmem_zero_blk;

    // Writes to register 0 are discarded, so they never satisfy a consumer.
    assign idex_zero_blk  = (ZERO_REG_EN != 0) && (IDEX_Rd == '0);
    assign exmem_zero_blk = (ZERO_REG_EN != 0) && (EXMEM_Rd == '0);

    // Per-operand match and select candidate. ID/EX is younger and wins over
    // EX/MEM; a load in ID/EX cannot forward yet and instead raises a hazard.
    always_comb begin
        logic [REG_ADDR_W-1:0] src;
        logic                  idex_hit;
        logic                  exmem_hit;
        cand     = '0;
        load_hit = 1'b0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            src       = ID_Src_Addr[i*REG_ADDR_W +: REG_ADDR_W];
            idex_hit  = ID_Src_Used[i] && IDEX_RegWrite && (IDEX_Rd == src) && !idex_zero_blk;
            exmem_hit = ID_Src_Used[i] && EXMEM_RegWrite && (EXMEM_Rd == src) && !exmem_zero_blk;
            if (idex_hit && !IDEX_MemRead)
                cand[2*i +: 2] = 2'b10;
            else if (exmem_hit)
                cand[2*i +: 2] = 2'b01;
            else
                cand[2*i +: 2] = 2'b00;
            if (idex_hit && IDEX_MemRead)
                load_hit = 1'b1;
        end
    end

    assign hazard = load_hit && ID_Valid && !ID_Flush;

    // State register
    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        if (ID_Flush) begin
            state_next = IDLE;
            cnt_next   = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (hazard) begin
                        state_next = STALL;
                        cnt_next   = CNT_W'(LOAD_STALL_CYCLES - 1);
                    end
                end
                STALL: begin
                    if (cnt != '0)
                        cnt_next = cnt - CNT_W'(1);
                    else
                        state_next = IDLE;
                end
                default: begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end
            endcase
        end
    end

    // Output logic; reset gates Stall so it drops without waiting for an edge
    // even while the hazard inputs are still present.
    always_comb begin
        Stall = 1'b0;
        if (RESET_N && !ID_Flush) begin
            case (state)
                IDLE:    Stall = hazard;
                STALL:   Stall = (cnt != '0);
                default: Stall = 1'b0;
            endcase
        end
    end

    assign IDEX_Bubble = Stall;

    // Forwarding selects: a bubble or squashed instruction entering EX
    // forwards nothing.
    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N)
            Fwd_Sel <= '0;
        else if (Stall || ID_Flush || !ID_Valid)
            Fwd_Sel <= '0;
        else
            Fwd_Sel <= cand;
    end

    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N)
            Stall_Count <= '0;
        else if (Stall && (Stall_Count != '1))
            Stall_Count <= Stall_Count + 16'd1;
    end

endmodule

// File: doc/fwd_hazard_unit.md
# fwd_hazard_unit

Parametrised forwarding and load-use hazard unit for the pipelined MIPS core. It evaluates the source operands of the instruction in ID against the destinations of the instructions in ID/EX and EX/MEM. It registers per-operand forwarding selects so they are valid in the same cycle the consumer reaches EX. It also detects load-use hazards, holds ID/IF for a configurable number of cycles, requests an ID/EX bubble, and counts stall cycles.

## Interface
- REG_ADDR_W, 5, register-address width
- NUM_SRC, 2, source operands per instruction
- LOAD_STALL_CYCLES, 1, stall cycles per load-use hazard (>=1)
- ZERO_REG_EN, 1, when 1, address 0 never matches

Ports:
- CLOCK  in  1  single clock; all state on rising edge
- RESET_N  in  1  asynchronous, active-low reset
- ID_Valid  in  1  ID holds a real instruction
- ID_Flush  in  1  ID instruction squashed (branch taken)
- ID_Src_Addr  in  NUM_SRC*REG_ADDR_W  source register addresses; operand i at bits [i*REG_ADDR_W +: REG_ADDR_W]
- ID_Src_Used  in  NUM_SRC  operand i is actually read
- IDEX_Rd  in  REG_ADDR_W  destination of instruction in ID/EX
- IDEX_RegWrite  in  1  ID/EX writes a register
- IDEX_MemRead  in  1  ID/EX is a load
- EXMEM_Rd  in  REG_ADDR_W  destination of instruction in EX/MEM
- EXMEM_RegWrite  in  1  EX/MEM writes a register
- Fwd_Sel  out  2*NUM_SRC  registered select, operand i at [2i+1:2i]: 00 register file, 01 MEM/WB result, 10 EX/MEM result
- Stall  out  1  hold PC and IF/ID this cycle (combinational)
- IDEX_Bubble  out  1  load a NOP into ID/EX this cycle; equal to Stall
- Stall_Count  out  16  saturating count of cycles with Stall=1

## Operation
- Match rule: a producer P matches operand i when all of the following hold: ID_Src_Used[i]; P_RegWrite; P_Rd == ID_Src_Addr[i]; and not (ZERO_REG_EN and P_Rd == 0).
- Per-operand select candidate:
  - 10 if ID/EX matches and IDEX_MemRead = 0.
  - else 01 if EX/MEM matches.
  - else 00.
  - When both producers match, the younger one (ID/EX) wins.
- Hazard: any operand matches ID/EX with IDEX_MemRead = 1, ID_Valid = 1 and ID_Flush = 0.
- FSM states are IDLE and STALL, with a counter cnt of width clog2(LOAD_STALL_CYCLES)+1.
  - IDLE with hazard: Stall = 1; next state STALL; cnt <= LOAD_STALL_CYCLES-1.
  - IDLE without hazard: Stall = 0; remain in IDLE.
  - STALL with cnt != 0: Stall = 1; cnt <= cnt-1.
  - STALL with cnt == 0: Stall = 0; next state IDLE. No hazard evaluation in this cycle.
  - ID_Flush = 1 in any state: Stall = 0; next state IDLE; cnt <= 0.
  - Total Stall-high cycles per hazard is exactly LOAD_STALL_CYCLES.
- Fwd_Sel register update on every edge:
  - Loads 00 for all operands when Stall, ID_Flush or !ID_Valid. A bubble entering EX forwards nothing.
  - Otherwise loads the candidate selects.
- Stall_Count increments on each edge where Stall = 1 and saturates at 16'hFFFF.
- With LOAD_STALL_CYCLES > 1, the load retires past MEM/WB before the consumer reaches EX. The register file must be write-before-read; this unit then selects 00.

## Timing
- Reset (RESET_N low, asynchronous) forces:
  - state IDLE, cnt 0
  - Fwd_Sel all 00
  - Stall_Count 0
  - Stall and IDEX_Bubble 0
- Release of RESET_N takes effect at the first rising edge after deassertion. Reset mid-stall abandons the stall immediately.
- Fwd_Sel latency is 1 cycle: it is computed from ID-stage inputs in cycle n and is valid for EX in cycle n+1.
- Stall and IDEX_Bubble are combinational from inputs and state, in the same cycle as detection.
- Stall_Count reflects cycle n's Stall after edge n+1.

## Test plan
- Reset with RESET_N=0 mid-STALL (LOAD_STALL_CYCLES=3, cnt=2) -> Stall, Fwd_Sel and Stall_Count drop to 0 immediately, without waiting for a clock edge; FSM is in IDLE after release.
- ALU RAW: IDEX_Rd=8, IDEX_RegWrite=1, MemRead=0; src0=8, src1=9; EXMEM_Rd=9, EXMEM_RegWrite=1 -> next cycle Fwd_Sel=4'b0110; Stall=0.
- Double match: IDEX_Rd=EXMEM_Rd=5, both writing, src0=5 -> Fwd_Sel[1:0]=10. With addresses 0 and ZERO_REG_EN=1 -> 00.
- Load-use, LOAD_STALL_CYCLES=1: IDEX_Rd=4, MemRead=1, src1=4 -> Stall=1 for exactly 1 cycle and Fwd_Sel=00 after it. Then, with the load in EX/MEM, src1 -> 01. Stall_Count=1.
- Load-use, LOAD_STALL_CYCLES=3 -> Stall high for 3 consecutive cycles, then low. Stall_Count=3. Asserting ID_Flush during cycle 2 ends the stall that cycle, and Stall_Count=1.
- Unused operand: ID_Src_Used=2'b01, src1=7 matching a load in ID/EX -> no stall; Fwd_Sel[3:2]=00.
- Saturation: Stall_Count preloaded via 65535 stalls -> stays 16'hFFFF.
